// File: rtl/sdram_slot_scheduler_if.sv
// Bundle of requester-side and SDRAM-core-side signals for the slot scheduler.
//
// Handshake: a requester raises req[p] with req_we/addr/din/ds stable and holds
// them until ack[p] pulses for exactly one cycle. That cycle completes the
// transfer, and rdata is valid in it for reads. Keeping req high after ack
// starts a new request. Dropping req before ack is not allowed.
interface sdram_slot_scheduler_if #(
  parameter int NPORTS = 3
);
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    req_we;
  logic [NPORTS*22-1:0] req_addr;
  logic [NPORTS*16-1:0] req_din;
  logic [NPORTS*2-1:0]  req_ds;
  logic [NPORTS-1:0]    ack;
  logic [15:0]          rdata;
  logic                 core_sync;
  logic                 core_oe;
  logic                 core_we;
  logic [21:0]          core_addr;
  logic [15:0]          core_din;
  logic [1:0]           core_ds;
  logic [15:0]          core_dout;
  // Debug view of the scheduler: slot cycle and whether this slot is granted.
  logic [7:0]           dbg_cnt;
  logic                 dbg_granted;

  modport slave (
    input  req, req_we, req_addr, req_din, req_ds, core_dout,
    output ack, rdata, core_sync, core_oe, core_we, core_addr, core_din,
           core_ds, dbg_cnt, dbg_granted
  );

  modport master (
    output req, req_we, req_addr, req_din, req_ds, core_dout,
    input  ack, rdata, core_sync, core_oe, core_we, core_addr, core_din,
           core_ds, dbg_cnt, dbg_granted
  );
endinterface

// File: rtl/sdram_slot_scheduler.sv
// Round-robin slot scheduler in front of a single-port, fixed-slot SDRAM core.
// One requester is picked per slot, its command is held for the whole slot,
// and a busy-slot counter forces an idle slot so core auto-refresh can run.
module sdram_slot_scheduler #(
  parameter int NPORTS       = 3,
  parameter int SLOT_CYCLES  = 8,
  parameter int RDATA_OFFSET = 6,
  parameter int REFRESH_MAX  = 7
) (
  input logic clk,
  input logic reset,
  sdram_slot_scheduler_if.slave bus
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int BW = $clog2(REFRESH_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_RDATA = CW'(RDATA_OFFSET);
  localparam logic [BW-1:0] BUSY_MAX  = BW'(REFRESH_MAX);
  localparam logic [1:0]    PTR_LAST  = 2'(NPORTS - 1);

  typedef enum logic {SLOT_IDLE = 1'b0, SLOT_GRANTED = 1'b1} slot_state_t;

  slot_state_t       state, state_next;
  logic [CW-1:0]     cnt;
  logic [1:0]        ptr, win_idx, grant_idx;
  logic [BW-1:0]     busy_cnt;
  logic [NPORTS-1:0] eligible, grant_oh, ack_q;
  logic              found, arb_edge, force_idle;
  logic              sel_we;
  logic [21:0]       sel_addr;
  logic [15:0]       sel_din;
  logic [1:0]        sel_ds;
  logic              sync_q, oe_q, we_q;
  logic [21:0]       addr_q;
  logic [15:0]       din_q, rdata_q;
  logic [1:0]        ds_q;

  // Round-robin search: the lowest offset from ptr among eligible ports wins.
  always_comb begin
    eligible = bus.req & ~ack_q;
    found    = 1'b0;
    win_idx  = ptr;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (eligible[p] &&
            (((int'(ptr) + k) >= NPORTS ? int'(ptr) + k - NPORTS : int'(ptr) + k) == p)) begin
          found   = 1'b1;
          win_idx = 2'(p);
        end
      end
    end
  end

  // Select the candidate winner's command and decode the current grant one-hot.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    sel_ds   = '0;
    grant_oh = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (win_idx == 2'(p)) begin
        sel_we   = bus.req_we[p];
        sel_addr = bus.req_addr[p*22 +: 22];
        sel_din  = bus.req_din[p*16 +: 16];
        sel_ds   = bus.req_ds[p*2 +: 2];
      end
      if (grant_idx == 2'(p)) grant_oh[p] = 1'b1;
    end
  end

  // Next slot state: decided only on the last cycle of the current slot.
  always_comb begin
    arb_edge   = (cnt == CNT_LAST);
    force_idle = (busy_cnt == BUSY_MAX);
    state_next = state;
    if (arb_edge) begin
      state_next = (found && !force_idle) ? SLOT_GRANTED : SLOT_IDLE;
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (reset) state <= SLOT_IDLE;
    else       state <= state_next;
  end

  // Slot counter, sync pulse, pointer, busy-slot counter and command registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      sync_q    <= 1'b0;
      ptr       <= '0;
      busy_cnt  <= '0;
      grant_idx <= '0;
      oe_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      ds_q      <= '0;
    end else begin
      cnt    <= arb_edge ? '0 : cnt + 1'b1;
      sync_q <= arb_edge;
      if (arb_edge) begin
        if (state_next == SLOT_GRANTED) begin
          grant_idx <= win_idx;
          ptr       <= (win_idx == PTR_LAST) ? 2'd0 : win_idx + 2'd1;
          busy_cnt  <= busy_cnt + 1'b1;
          oe_q      <= ~sel_we;
          we_q      <= sel_we;
          addr_q    <= sel_addr;
          din_q     <= sel_din;
          ds_q      <= sel_ds;
        end else begin
          // Idle slot: command strobes drop, address/data keep their values.
          busy_cnt <= '0;
          oe_q     <= 1'b0;
          we_q     <= 1'b0;
        end
      end
    end
  end

  // Completion: capture core data and pulse ack for the granted port once per slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      if (state == SLOT_GRANTED && cnt == CNT_RDATA) begin
        ack_q   <= grant_oh;
        rdata_q <= bus.core_dout;
      end
    end
  end

  assign bus.ack         = ack_q;
  assign bus.rdata       = rdata_q;
  assign bus.core_sync   = sync_q;
  assign bus.core_oe     = oe_q;
  assign bus.core_we     = we_q;
  assign bus.core_addr   = addr_q;
  assign bus.core_din    = din_q;
  assign bus.core_ds     = ds_q;
  assign bus.dbg_cnt     = 8'(cnt);
  assign bus.dbg_granted = (state == SLOT_GRANTED);
endmodule

// File: tb/tb_sdram_slot_scheduler.sv
// Directed bench for sdram_slot_scheduler: scenarios push expected slot
// commands and acks into queues; a negedge monitor pops and compares them.
module tb_sdram_slot_scheduler;
  logic clk;
  logic reset;

  sdram_slot_scheduler_if #(.NPORTS(3)) bus ();

  sdram_slot_scheduler #(
    .NPORTS(3), .SLOT_CYCLES(8), .RDATA_OFFSET(6), .REFRESH_MAX(7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;   // cycles since reset release, counted by the bench
  int drv_cyc  = 0;
  bit mon_en   = 0;

  always @(posedge clk) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  // ---------------- core data model ----------------
  bit          use_model = 0;
  logic [15:0] dout_reg  = 16'h0000;

  function automatic logic [15:0] model(input logic [21:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  assign bus.core_dout = use_model ? model(bus.core_addr) : dout_reg;

  // ---------------- scoreboard ----------------
  logic [41:0] exp_cmd_q[$];   // {oe, we, addr, din, ds}
  logic [18:0] exp_ack_q[$];   // {port, is_read, rdata}
  logic [41:0] cur_cmd;
  logic [18:0] cur_ack;
  logic [2:0]  exp_oh;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == 0) begin
        cur_cmd = '0;
        check("reset_ack_rdata", {bus.ack, bus.rdata}, 64'd0);
      end
      if (cyc >= 8 && cyc % 8 == 0) begin
        if (exp_cmd_q.size() == 0) begin
          n_checks++;
          $display("FAIL cmd_queue: slot at cycle %0d has no expected command", cyc);
        end else begin
          cur_cmd = exp_cmd_q.pop_front();
        end
      end
      check("core_sync", 64'(bus.core_sync), 64'(cyc >= 8 && cyc % 8 == 0));
      check("core_cmd", {bus.core_oe, bus.core_we, bus.core_addr, bus.core_din, bus.core_ds}, cur_cmd);
      if (bus.ack != '0) begin
        check("ack_phase", 64'(cyc % 8), 64'd7);
        if (exp_ack_q.size() == 0) begin
          n_checks++;
          $display("FAIL ack_queue: unexpected ack 0x%0h, expected none", bus.ack);
        end else begin
          cur_ack = exp_ack_q.pop_front();
          exp_oh  = 3'b001 << cur_ack[18:17];
          check("ack_port", bus.ack, exp_oh);
          if (cur_ack[16]) check("rdata", bus.rdata, cur_ack[15:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic        p_we[3];
  logic [21:0] p_addr[3];
  logic [15:0] p_din[3];
  logic [1:0]  p_ds[3];
  logic [21:0] last_addr;
  logic [15:0] last_din;
  logic [1:0]  last_ds;

  task automatic go_cycle(input int c);
    while (drv_cyc < c) begin
      @(posedge clk);
      #1;
      drv_cyc++;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    @(posedge clk);
    #1;
    mon_en = 1;
    check("cmd_q_drained", 64'(exp_cmd_q.size()), 64'd0);
    check("ack_q_drained", 64'(exp_ack_q.size()), 64'd0);
    exp_cmd_q.delete();
    exp_ack_q.delete();
    last_addr = '0;
    last_din  = '0;
    last_ds   = '0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    drv_cyc = 0;
  endtask

  task automatic set_port(input int p, input logic we, input logic [21:0] a,
                          input logic [15:0] d, input logic [1:0] s);
    p_we[p] = we; p_addr[p] = a; p_din[p] = d; p_ds[p] = s;
    bus.req_we[p]          = we;
    bus.req_addr[p*22 +: 22] = a;
    bus.req_din[p*16 +: 16]  = d;
    bus.req_ds[p*2 +: 2]     = s;
  endtask

  task automatic push_grant(input int p, input bit with_ack);
    exp_cmd_q.push_back({~p_we[p], p_we[p], p_addr[p], p_din[p], p_ds[p]});
    last_addr = p_addr[p]; last_din = p_din[p]; last_ds = p_ds[p];
    if (with_ack)
      exp_ack_q.push_back({2'(p), ~p_we[p], use_model ? model(p_addr[p]) : dout_reg});
  endtask

  task automatic push_idle();
    exp_cmd_q.push_back({1'b0, 1'b0, last_addr, last_din, last_ds});
  endtask

  // ---------------- scenarios ----------------
  int s4_grant[10] = '{0, 1, 0, 1, 0, 1, 0, -1, 1, 0};

  initial begin
    reset        = 1'b1;
    bus.req      = '0;
    bus.req_we   = '0;
    bus.req_addr = '0;
    bus.req_din  = '0;
    bus.req_ds   = '0;
    do_reset();

    // Single read on port 1: one read slot, then an idle slot.
    use_model = 0; dout_reg = 16'hBEEF;
    set_port(1, 1'b0, 22'h000123, 16'h0000, 2'b11);
    bus.req = 3'b010;
    push_grant(1, 1); push_idle();
    go_cycle(16); bus.req[1] = 1'b0;
    go_cycle(23); do_reset();

    // Single write on port 0.
    set_port(0, 1'b1, 22'h2A5A5A, 16'h1234, 2'b01);
    bus.req = 3'b001;
    push_grant(0, 1); push_idle();
    go_cycle(16); bus.req[0] = 1'b0;
    go_cycle(23); do_reset();

    // Round-robin with all three ports requesting continuously.
    use_model = 1;
    set_port(0, 1'b0, 22'h000010, 16'h0000, 2'b11);
    set_port(1, 1'b1, 22'h111111, 16'hCAFE, 2'b10);
    set_port(2, 1'b0, 22'h3FFFFF, 16'h0F0F, 2'b11);
    bus.req = 3'b111;
    for (int i = 0; i < 6; i++) push_grant(i % 3, 1);
    go_cycle(55); do_reset();

    // Refresh starvation: seven busy slots, one forced idle, then resume.
    set_port(0, 1'b0, 22'h000ABC, 16'h0000, 2'b11);
    set_port(1, 1'b1, 22'h200001, 16'h55AA, 2'b10);
    bus.req = 3'b011;
    for (int i = 0; i < 10; i++) begin
      if (s4_grant[i] < 0) push_idle();
      else                 push_grant(s4_grant[i], 1);
    end
    go_cycle(87); do_reset();

    // No requests: idle slots, sync every 8 clocks, no ack.
    for (int i = 0; i < 3; i++) push_idle();
    go_cycle(31); do_reset();

    // Reset at slot cycle 3 of a granted read: no ack, clean restart.
    set_port(2, 1'b0, 22'h155555, 16'h0000, 2'b11);
    bus.req = 3'b100;
    push_grant(2, 0);
    go_cycle(11); do_reset();
    push_idle();
    go_cycle(15); do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
